// File: rtl/fx_slide_sched.sv
// Round-robin pitch-slide scheduler: one shared glide datapath serves four
// voice channels, one channel per note_clk tick.
module fx_slide_sched #(
   parameter int NCH     = 4,
   parameter int OFF_MAX = 63
) (
   input  logic        note_clk,
   input  logic        rst,
   input  logic [23:0] note_in,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_ch,
   input  logic [1:0]  cfg_speed,
   input  logic        cfg_dir,
   input  logic        cfg_en,
   input  logic        cfg_retrig,
   output logic [23:0] note_out,
   output logic        out_valid,
   output logic [1:0]  out_ch,
   output logic        busy
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state_q, state_d;
   logic [1:0]     ptr_q, ptr_d;
   logic [NCH-1:0] en_q;
   logic [NCH-1:0] dir_q;
   logic [1:0]     spd_q [NCH];
   logic [1:0]     cnt_q [NCH];
   logic [5:0]     off_q [NCH];

   logic           svc;
   logic           step;
   logic [5:0]     base;
   logic [5:0]     slid;
   logic [5:0]     off_nxt;

   always_comb begin
      base    = note_in[int'(ptr_q)*6 +: 6];
      step    = en_q[ptr_q] && (cnt_q[ptr_q] >= spd_q[ptr_q]);
      slid    = dir_q[ptr_q] ? (base + off_q[ptr_q]) : (base - off_q[ptr_q]);
      off_nxt = (off_q[ptr_q] == 6'(OFF_MAX)) ? off_q[ptr_q] : off_q[ptr_q] + 6'd1;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      svc     = 1'b0;
      case (state_q)
         IDLE: begin
            ptr_d = '0;
            if (|en_q) state_d = RUN;
         end
         RUN: begin
            svc   = 1'b1;
            ptr_d = ptr_q + 2'd1;
            if (ptr_q == 2'd3 && !(|en_q)) begin
               state_d = IDLE;
               ptr_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge note_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign busy = (state_q == RUN);

   always_ff @(posedge note_clk or posedge rst) begin
      if (rst) begin
         en_q      <= '0;
         dir_q     <= '0;
         note_out  <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            spd_q[i] <= '0;
            cnt_q[i] <= '0;
            off_q[i] <= '0;
         end
      end else begin
         out_valid <= svc;
         if (svc) begin
            out_ch <= ptr_q;
            if (!en_q[ptr_q]) begin
               cnt_q[ptr_q] <= '0;
               off_q[ptr_q] <= '0;
               note_out[int'(ptr_q)*6 +: 6] <= base;
            end else if (step) begin
               cnt_q[ptr_q] <= '0;
               off_q[ptr_q] <= off_nxt;
               note_out[int'(ptr_q)*6 +: 6] <= slid;
            end else begin
               cnt_q[ptr_q] <= cnt_q[ptr_q] + 2'd1;
            end
         end
         // Config write follows the service so a same-edge retrig clear wins.
         if (cfg_we) begin
            spd_q[cfg_ch] <= cfg_speed;
            dir_q[cfg_ch] <= cfg_dir;
            en_q[cfg_ch]  <= cfg_en;
            if (cfg_retrig) begin
               cnt_q[cfg_ch] <= '0;
               off_q[cfg_ch] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fx_slide_sched.sv
// Scoreboard bench for fx_slide_sched: driver predicts each edge from a
// channel-level slide model, monitor checks outputs as the DUT emits them.
module tb_fx_slide_sched;

   logic        note_clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] note_in = '0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [1:0]  cfg_speed = '0;
   logic        cfg_dir = 1'b0;
   logic        cfg_en = 1'b0;
   logic        cfg_retrig = 1'b0;
   logic [23:0] note_out;
   logic        out_valid;
   logic [1:0]  out_ch;
   logic        busy;

   fx_slide_sched #(.NCH(4), .OFF_MAX(63)) dut (
      .note_clk  (note_clk),
      .rst       (rst),
      .note_in   (note_in),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_speed (cfg_speed),
      .cfg_dir   (cfg_dir),
      .cfg_en    (cfg_en),
      .cfg_retrig(cfg_retrig),
      .note_out  (note_out),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .busy      (busy)
   );

   always #5 note_clk = ~note_clk;

   typedef struct {
      int          tag;
      int          ch;
      logic [23:0] notes;
   } exp_t;

   exp_t exp_q[$];
   bit   busy_q[$];
   int   vectors = 0;
   int   errors = 0;
   int   edge_n = 0;
   bit   mon_on = 1'b0;

   // Reference model: per-channel slide state at the behavioural level.
   bit m_run;
   int m_ptr;
   int m_en[4], m_spd[4], m_dir[4], m_cnt[4], m_off[4], m_note[4];

   function automatic void chk(string name, longint act, longint expv);
      vectors++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_n);
      end
   endfunction

   function automatic void model_reset();
      m_run = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < 4; i++) begin
         m_en[i] = 0; m_spd[i] = 0; m_dir[i] = 0;
         m_cnt[i] = 0; m_off[i] = 0; m_note[i] = 0;
      end
   endfunction

   function automatic logic [23:0] packed_notes();
      logic [23:0] p;
      for (int i = 0; i < 4; i++) p[i*6 +: 6] = 6'(m_note[i]);
      return p;
   endfunction

   function automatic void model_edge(int tag);
      int c, n;
      exp_t e;
      bit any_en;
      any_en = (m_en[0] | m_en[1] | m_en[2] | m_en[3]) != 0;
      if (m_run) begin
         c = m_ptr;
         n = int'(note_in[c*6 +: 6]);
         if (m_en[c] == 0) begin
            m_cnt[c] = 0; m_off[c] = 0; m_note[c] = n;
         end else if (m_cnt[c] >= m_spd[c]) begin
            m_cnt[c] = 0;
            m_note[c] = m_dir[c] != 0 ? (n + m_off[c]) % 64 : (n - m_off[c] + 64) % 64;
            m_off[c] = (m_off[c] + 1 > 63) ? 63 : m_off[c] + 1;
         end else begin
            m_cnt[c]++;
         end
         e.tag = tag; e.ch = c; e.notes = packed_notes();
         exp_q.push_back(e);
         if (c == 3 && !any_en) begin m_run = 1'b0; m_ptr = 0; end
         else m_ptr = (m_ptr + 1) % 4;
      end else if (any_en) begin
         m_run = 1'b1;
      end
      if (cfg_we) begin
         m_spd[cfg_ch] = int'(cfg_speed);
         m_dir[cfg_ch] = int'(cfg_dir);
         m_en[cfg_ch]  = int'(cfg_en);
         if (cfg_retrig) begin m_cnt[cfg_ch] = 0; m_off[cfg_ch] = 0; end
      end
      busy_q.push_back(m_run);
   endfunction

   // Called at a negedge: drive, predict the coming edge, wait for the next negedge.
   task automatic tick(bit we, int ch, int sp, bit dr, bit en, bit rt);
      cfg_we = we; cfg_ch = 2'(ch); cfg_speed = 2'(sp);
      cfg_dir = dr; cfg_en = en; cfg_retrig = rt;
      model_edge(edge_n + 1);
      @(negedge note_clk);
   endtask

   task automatic idle_ticks(int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
   endtask

   task automatic set_note(int ch, int v);
      note_in[ch*6 +: 6] = 6'(v);
   endtask

   task automatic wait_ptr(int p);
      for (int i = 0; i < 8 && !(m_run && m_ptr == p); i++) tick(0, 0, 0, 0, 0, 0);
      chk("ptr_reach", (m_run && m_ptr == p) ? 1 : 0, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cfg_we = 1'b0;
      #1;
      chk("rst_note_out", note_out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_busy", busy, 0);
      model_reset();
      exp_q.delete();
      busy_q.delete();
      busy_q.push_back(1'b0);
      @(negedge note_clk);
      rst = 1'b0;
   endtask

   always @(posedge note_clk) begin
      exp_t e;
      edge_n++;
      #1;
      if (mon_on) begin
         if (busy_q.size() == 0) chk("busy_q_underflow", 1, 0);
         else chk("busy", busy, busy_q.pop_front());
         if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("service_edge", edge_n, e.tag);
               chk("out_ch", out_ch, e.ch);
               chk("note_out", note_out, e.notes);
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) @(negedge note_clk);
      mon_on = 1'b1;
      do_reset();

      // Single channel slide up from 10.
      set_note(0, 10);
      tick(1, 0, 0, 1, 1, 0);
      idle_ticks(20);

      // Slower downward slide.
      set_note(1, 20);
      tick(1, 1, 2, 0, 1, 0);
      idle_ticks(40);

      // Mod-64 wrap and offset saturation.
      set_note(2, 62);
      tick(1, 2, 0, 1, 1, 1);
      idle_ticks(300);

      // Retrig on the edge ch0 is serviced.
      wait_ptr(0);
      tick(1, 0, 0, 1, 1, 1);
      idle_ticks(12);

      // Disable everything, last write landing while ch1 is serviced.
      tick(1, 1, 0, 0, 0, 0);
      tick(1, 2, 0, 0, 0, 0);
      wait_ptr(1);
      tick(1, 0, 0, 0, 0, 0);
      idle_ticks(10);
      chk("idle_after_disable", busy, 0);

      // Reset mid-run with offsets nonzero, then a fresh slide.
      set_note(3, 40);
      tick(1, 3, 0, 0, 1, 0);
      tick(1, 0, 1, 1, 1, 0);
      idle_ticks(30);
      do_reset();
      tick(1, 3, 0, 0, 1, 0);
      idle_ticks(20);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) note_in = 24'($urandom);
         if ($urandom_range(0, 599) == 0) do_reset();
         else if ($urandom_range(0, 11) == 0)
            tick(1, $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
         else
            tick(0, 0, 0, 0, 0, 0);
      end

      mon_on = 1'b0;
      chk("exp_q_drained", exp_q.size(), 0);
      chk("busy_q_drained", busy_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/fx_slide_sched.md
Name: fx_slide_sched

Overview:
Time-multiplexed scheduler that shares one slide (pitch-glide) datapath among 4 voice channels. It holds per-channel slide state (speed, direction, enable, tick count, offset) and services one channel per note_clk tick in round-robin order. It produces each channel's slid 6-bit note index. It sits between the sequencer's per-voice note registers and the tone generators, and is configured by the control bus.

Parameters:
NCH, 4, number of channels; fixed at 4, pointer is 2 bits.
OFF_MAX, 63, saturation limit of per-channel offset (0..63).

Ports:
note_clk  in  1  note tick clock; all state on its rising edge.
rst  in  1  asynchronous, active-high reset.
note_in  in  24  packed base notes; channel c = bits [6c+5:6c].
cfg_we  in  1  config write strobe, one write per cycle.
cfg_ch  in  2  channel addressed by the write.
cfg_speed  in  2  ticks-per-step minus 1 (0 = step every service).
cfg_dir  in  1  0 = slide down, 1 = slide up.
cfg_en  in  1  channel slide enable.
cfg_retrig  in  1  clear the channel's offset and count on this write.
note_out  out  24  packed slid notes, same packing as note_in.
out_valid  out  1  1-cycle pulse: note_out for out_ch updated last edge.
out_ch  out  2  channel updated with out_valid.
busy  out  1  1 while in RUN state.

Behaviour:
- Reset (async): all per-channel speed/dir/en/count/offset = 0; note_out = 0; out_valid = 0; out_ch = 0; ptr = 0; state = IDLE; busy = 0.
- Config write (cfg_we=1): at the edge, write speed, dir and en for cfg_ch. If cfg_retrig=1, also clear offset[cfg_ch] and count[cfg_ch].
- FSM states:
  - IDLE: ptr held at 0, no outputs updated. Go to RUN at the edge after any en bit becomes 1, using registered en.
  - RUN: busy=1. Each edge, service channel ptr, then ptr <= ptr+1 (3 wraps to 0). Return to IDLE when all en=0 at the end of a full rotation (ptr==3 serviced); ptr then resets to 0.
- Service of channel c in RUN, using pre-edge state:
  - en[c]=1 and count[c] >= speed[c]: count <= 0. note_out[c] <= note_in[c] + offset[c] if dir=1, else note_in[c] - offset[c]. Arithmetic is mod 64 (wraps; no note clamping). Then offset <= min(offset+1, OFF_MAX).
  - en[c]=1 and count[c] < speed[c]: count <= count+1; note_out[c] unchanged.
  - en[c]=0: count <= 0, offset <= 0, note_out[c] <= note_in[c] (passthrough).
  - In all three cases: out_valid <= 1 and out_ch <= c at the same edge.
- The first step after enable/retrig outputs note_in + 0. The offset applied lags the increment by one step.
- In IDLE: out_valid = 0 and note_out holds.
- Per-channel service period = 4 edges. A step on a channel therefore occurs every 4*(speed+1) edges.
- Simultaneous write and service of the same channel: service uses old config and state. The write then takes effect. Retrig clear overrides the service's count and offset update. Written speed/dir/en override nothing else.
- note_in is sampled only at the serviced channel's edge; changes between services are invisible.
- Offset saturates at OFF_MAX and holds there until disable or retrig.
- Reset mid-rotation returns to IDLE immediately; no partial update survives.

Test Plan:
- Reset, then write ch0 en=1 speed=0 dir=1; note_in ch0=10 -> after IDLE->RUN, ch0 services every 4 edges output 10,11,12,13; out_ch cycles 0,1,2,3 with out_valid every edge.
- ch1 en=1 speed=2 dir=0, note_in=20 -> ch1 values 20,19,18 appear at ch1 services 1,4,7, with counts 1,2 in between and note_out held.
- ch2 dir=1 note_in=62, speed=0 -> outputs 62,63,0,1 (mod-64 wrap). Run 70 steps -> offset sticks at 63.
- Write ch0 with retrig=1 in the same edge ch0 is serviced (offset=5) -> that edge outputs note_in+5; the next ch0 service outputs note_in+0.
- Disable all channels mid-rotation at ptr=1 -> services continue through ptr=3 with passthrough; then state=IDLE, busy=0, out_valid=0, ptr=0.
- Assert rst while RUN with offsets nonzero -> all outputs 0 immediately. Re-enable gives a fresh slide starting at offset 0.
